// File: rtl/vga_frame_reader_pkg.sv
// Shared constants and types for the VGA display-side frame reader.
// Visible raster size, default source image size, luma weights and the RGB565 pixel layout.
package vga_pkg;

  localparam int H_VISIBLE     = 640;
  localparam int V_VISIBLE     = 480;
  localparam int IMG_W_DEFAULT = 320;
  localparam int IMG_H_DEFAULT = 240;

  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port between the display reader (master) and the banked buffer (slave).
interface vga_frame_reader_if #(
  parameter int ADDR_W = 17
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank;
  logic [15:0]       rd_data;

  modport master (output rd_en, output rd_addr, output rd_bank, input rd_data);
  modport slave  (input rd_en, input rd_addr, input rd_bank, output rd_data);

endinterface

// File: rtl/vga_frame_reader_rgb565_to_gray.sv
// Combinational RGB565 to 8-bit luma: channels are widened to 8 bits by bit replication, then weighted.
module rgb565_to_gray
  import vga_pkg::*;
(
  input  rgb565_t    pix,
  output logic [7:0] luma
);

  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [15:0] sum;

  always_comb begin
    r8   = {pix.r, pix.r[4:2]};
    g8   = {pix.g, pix.g[5:4]};
    b8   = {pix.b, pix.b[4:2]};
    // Weights add up to 256, so the 16-bit sum cannot overflow.
    sum  = 16'(LUMA_R) * {8'd0, r8} + 16'(LUMA_G) * {8'd0, g8} + 16'(LUMA_B) * {8'd0, b8};
    luma = 8'(sum >> 8);
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Two-stage pixel-strobe pipeline that fetches QVGA RGB565 pixels from a double-banked buffer,
// optionally upscales/greys them and drives RGB444 with syncs and DE delayed to match.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEFAULT,
  parameter int IMG_H  = IMG_H_DEFAULT,
  parameter int ADDR_W = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pclk,
  input  logic [9:0]          x_pixel,
  input  logic [9:0]          y_pixel,
  input  logic                DE,
  input  logic                h_sync,
  input  logic                v_sync,
  input  logic                zoom,
  input  logic                gray,
  input  logic                frame_wr_done,
  vga_frame_reader_if.master  fb,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_de,
  output logic                frame_start
);

  logic              rd_en_q,        rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q,      rd_addr_d;
  logic              rd_bank_q,      rd_bank_d;
  logic              swap_pending_q, swap_pending_d;
  logic              zoom_sh_q,      zoom_sh_d;
  logic              gray_sh_q,      gray_sh_d;
  logic              frame_start_q,  frame_start_d;
  logic              s1_in_img_q,    s1_in_img_d;
  logic              s1_de_q,        s1_de_d;
  logic              s1_hs_q,        s1_hs_d;
  logic              s1_vs_q,        s1_vs_d;
  logic              hold_vld_q,     hold_vld_d;
  rgb565_t           hold_q,         hold_d;
  logic [3:0]        vga_r_q,        vga_r_d;
  logic [3:0]        vga_g_q,        vga_g_d;
  logic [3:0]        vga_b_q,        vga_b_d;
  logic              vga_hs_q,       vga_hs_d;
  logic              vga_vs_q,       vga_vs_d;
  logic              vga_de_q,       vga_de_d;

  logic              swap_pt;
  logic              in_img;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        luma;

  rgb565_to_gray u_gray (
    .pix  (hold_q),
    .luma (luma)
  );

  always_comb begin
    swap_pt = pclk && (x_pixel == 10'd0) && (y_pixel == 10'(V_VISIBLE));
    in_img  = zoom_sh_q ? DE
                        : (DE && (x_pixel < 10'(IMG_W)) && (y_pixel < 10'(IMG_H)));
    row     = zoom_sh_q ? ADDR_W'(y_pixel[9:1]) : ADDR_W'(y_pixel);
    col     = zoom_sh_q ? ADDR_W'(x_pixel[9:1]) : ADDR_W'(x_pixel);
    addr    = row * ADDR_W'(IMG_W) + col;
  end

  always_comb begin
    rd_en_d        = pclk && in_img;
    rd_addr_d      = rd_addr_q;
    rd_bank_d      = rd_bank_q;
    swap_pending_d = swap_pending_q | frame_wr_done;
    zoom_sh_d      = zoom_sh_q;
    gray_sh_d      = gray_sh_q;
    frame_start_d  = swap_pt;
    hold_vld_d     = rd_en_q;
    hold_d         = hold_q;
    s1_in_img_d    = s1_in_img_q;
    s1_de_d        = s1_de_q;
    s1_hs_d        = s1_hs_q;
    s1_vs_d        = s1_vs_q;
    vga_r_d        = vga_r_q;
    vga_g_d        = vga_g_q;
    vga_b_d        = vga_b_q;
    vga_hs_d       = vga_hs_q;
    vga_vs_d       = vga_vs_q;
    vga_de_d       = vga_de_q;

    if (pclk && in_img) begin
      rd_addr_d = addr;
    end

    // Read data arrives one clk after rd_en; park it until the next strobe consumes it.
    if (hold_vld_q) begin
      hold_d = fb.rd_data;
    end

    // Modes and the displayed bank only change at the start of vertical blank.
    if (swap_pt) begin
      zoom_sh_d      = zoom;
      gray_sh_d      = gray;
      swap_pending_d = 1'b0;
      if (swap_pending_q || frame_wr_done) begin
        rd_bank_d = ~rd_bank_q;
      end
    end

    if (pclk) begin
      s1_in_img_d = in_img;
      s1_de_d     = DE;
      s1_hs_d     = h_sync;
      s1_vs_d     = v_sync;
      vga_de_d    = s1_de_q;
      vga_hs_d    = s1_hs_q;
      vga_vs_d    = s1_vs_q;
      vga_r_d     = 4'd0;
      vga_g_d     = 4'd0;
      vga_b_d     = 4'd0;
      if (s1_in_img_q) begin
        if (gray_sh_q) begin
          vga_r_d = luma[7:4];
          vga_g_d = luma[7:4];
          vga_b_d = luma[7:4];
        end else begin
          vga_r_d = hold_q.r[4:1];
          vga_g_d = hold_q.g[5:2];
          vga_b_d = hold_q.b[4:1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      rd_bank_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      zoom_sh_q      <= 1'b0;
      gray_sh_q      <= 1'b0;
      frame_start_q  <= 1'b0;
      hold_vld_q     <= 1'b0;
      hold_q         <= '0;
      s1_in_img_q    <= 1'b0;
      s1_de_q        <= 1'b0;
      s1_hs_q        <= 1'b1;
      s1_vs_q        <= 1'b1;
      vga_r_q        <= 4'd0;
      vga_g_q        <= 4'd0;
      vga_b_q        <= 4'd0;
      vga_hs_q       <= 1'b1;
      vga_vs_q       <= 1'b1;
      vga_de_q       <= 1'b0;
    end else begin
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      rd_bank_q      <= rd_bank_d;
      swap_pending_q <= swap_pending_d;
      zoom_sh_q      <= zoom_sh_d;
      gray_sh_q      <= gray_sh_d;
      frame_start_q  <= frame_start_d;
      hold_vld_q     <= hold_vld_d;
      hold_q         <= hold_d;
      s1_in_img_q    <= s1_in_img_d;
      s1_de_q        <= s1_de_d;
      s1_hs_q        <= s1_hs_d;
      s1_vs_q        <= s1_vs_d;
      vga_r_q        <= vga_r_d;
      vga_g_q        <= vga_g_d;
      vga_b_q        <= vga_b_d;
      vga_hs_q       <= vga_hs_d;
      vga_vs_q       <= vga_vs_d;
      vga_de_q       <= vga_de_d;
    end
  end

  assign fb.rd_en     = rd_en_q;
  assign fb.rd_addr   = rd_addr_q;
  assign fb.rd_bank   = rd_bank_q;
  assign vga_r        = vga_r_q;
  assign vga_g        = vga_g_q;
  assign vga_b        = vga_b_q;
  assign vga_hs       = vga_hs_q;
  assign vga_vs       = vga_vs_q;
  assign vga_de       = vga_de_q;
  assign frame_start  = frame_start_q;

endmodule
